xg_mdu_iter: RTL

- Iterative RV32M/RV64M multiply/divide unit for the XG pipeline. It sits beside the ALU in the EX stage.
- The EX stage hands it operands plus an operation. The unit holds the pipeline stalled while it computes, then returns a result tagged with the destination register.
- It is a parametrised successor to the single-cycle ALU path. Operand width and bits retired per cycle are both configurable.
- It supports flush-abort, so a branch resolved in Decode can kill an in-flight operation.

---
 rtl/xg_mdu_iter_if.sv | 31 +++
 rtl/xg_mdu_iter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/xg_mdu_iter_if.sv
// rtl/xg_mdu_iter_if.sv - request/response bundle between the EX stage and xg_mdu_iter
// Signals:
//   valid_in, op, srca, srcb, rd_in, flush : request side, driven by the EX stage (master)
//   ready, stall                           : flow control, driven by the unit (slave)
//   done, result, rd_out                   : completion, driven by the unit (slave)
interface xg_mdu_iter_if #(
    parameter int XLEN        = 32,
    parameter int RFIDX_WIDTH = 5
);
    logic                   valid_in;
    logic                   ready;
    logic [2:0]             op;
    logic [XLEN-1:0]        srca;
    logic [XLEN-1:0]        srcb;
    logic [RFIDX_WIDTH-1:0] rd_in;
    logic                   flush;
    logic                   stall;
    logic                   done;
    logic [XLEN-1:0]        result;
    logic [RFIDX_WIDTH-1:0] rd_out;

    modport master (
        output valid_in, op, srca, srcb, rd_in, flush,
        input  ready, stall, done, result, rd_out
    );

    modport slave (
        input  valid_in, op, srca, srcb, rd_in, flush,
        output ready, stall, done, result, rd_out
    );
endinterface

// File: rtl/xg_mdu_iter.sv
// rtl/xg_mdu_iter.sv - iterative RV32M/RV64M multiply/divide unit with flush-abort
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : xg_mdu_iter_if.slave
//           in : valid_in, op (funct3), srca, srcb, rd_in, flush
//           out: ready (IDLE), stall (CALC/FIX), done (one-cycle pulse),
//                result, rd_out (held until the next done)
module xg_mdu_iter #(
    parameter int XLEN        = 32,
    parameter int BPC         = 1,
    parameter int RFIDX_WIDTH = 5
) (
    input  logic         clk,
    input  logic         reset,
    xg_mdu_iter_if.slave bus
);
    localparam int N_ITER = XLEN / BPC;
    localparam int CNT_W  = $clog2(N_ITER + 1);
    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_REM    = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state;
    state_t next_state;

    logic [CNT_W-1:0]       cnt;
    logic [2:0]             op_q;
    logic [RFIDX_WIDTH-1:0] rd_q;
    logic [RFIDX_WIDTH-1:0] rd_out_q;
    logic [XLEN-1:0]        mag_b;
    logic [XLEN-1:0]        result_q;
    // Multiply: {partial product high, remaining multiplier bits}.
    // Divide:   {partial remainder, dividend bits shifting into quotient}.
    // Both start as {0, |srca|}, so the load path is shared.
    logic [2*XLEN-1:0]      acc;
    logic                   neg_q;   // product / quotient sign
    logic                   neg_r;   // remainder sign (sign of dividend)

    logic                   accept;
    logic                   a_signed;
    logic                   b_signed;
    logic                   sign_a;
    logic                   sign_b;
    logic                   special;
    logic [XLEN-1:0]        abs_a;
    logic [XLEN-1:0]        abs_b;
    logic [XLEN-1:0]        special_val;

    logic [XLEN-1:0]        hi;
    logic [XLEN-1:0]        lo;
    logic [XLEN+BPC-1:0]    psum;
    logic [XLEN:0]          rem_sh;
    logic [2*XLEN-1:0]      acc_step;

    logic [2*XLEN-1:0]      prod;
    logic [XLEN-1:0]        quo_fix;
    logic [XLEN-1:0]        rem_fix;
    logic [XLEN-1:0]        fix_val;

    assign accept = (state == S_IDLE) && bus.valid_in && !bus.flush;

    // Request decode: operand magnitudes, signs and the cases that skip CALC.
    always_comb begin
        a_signed = (bus.op == OP_MULH) || (bus.op == OP_MULHSU) ||
                   (bus.op == OP_DIV)  || (bus.op == OP_REM);
        b_signed = (bus.op == OP_MULH) || (bus.op == OP_DIV) || (bus.op == OP_REM);
        sign_a   = a_signed & bus.srca[XLEN-1];
        sign_b   = b_signed & bus.srcb[XLEN-1];
        abs_a    = sign_a ? -bus.srca : bus.srca;
        abs_b    = sign_b ? -bus.srcb : bus.srcb;

        special     = 1'b0;
        special_val = '0;
        if (bus.op[2]) begin
            if (bus.srcb == '0) begin
                special     = 1'b1;
                special_val = bus.op[1] ? bus.srca : '1;
            end else if (!bus.op[0] && (bus.srca == SMIN) && (bus.srcb == '1)) begin
                // Signed overflow: quotient wraps to srca, remainder is zero.
                special     = 1'b1;
                special_val = bus.op[1] ? '0 : bus.srca;
            end
        end
    end

    // One CALC cycle worth of work: BPC shift-add or restoring-divide steps.
    always_comb begin
        hi     = acc[2*XLEN-1:XLEN];
        lo     = acc[XLEN-1:0];
        psum   = '0;
        rem_sh = '0;
        if (op_q[2]) begin
            for (int i = 0; i < BPC; i++) begin
                rem_sh = {hi, lo[XLEN-1]};
                lo     = {lo[XLEN-2:0], 1'b0};
                if (rem_sh >= {1'b0, mag_b}) begin
                    rem_sh = rem_sh - {1'b0, mag_b};
                    lo[0]  = 1'b1;
                end
                hi = rem_sh[XLEN-1:0];
            end
            acc_step = {hi, lo};
        end else begin
            psum = {{BPC{1'b0}}, hi};
            for (int i = 0; i < BPC; i++) begin
                if (lo[i]) begin
                    psum = psum + ({{BPC{1'b0}}, mag_b} << i);
                end
            end
            acc_step = {psum, lo[XLEN-1:BPC]};
        end
    end

    // Sign fix-up and result selection.
    always_comb begin
        prod    = neg_q ? -acc : acc;
        quo_fix = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem_fix = neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        if (op_q[2]) begin
            fix_val = op_q[1] ? rem_fix : quo_fix;
        end else if (op_q[1:0] == 2'b00) begin
            fix_val = prod[XLEN-1:0];
        end else begin
            fix_val = prod[2*XLEN-1:XLEN];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        bus.ready  = 1'b0;
        bus.stall  = 1'b0;
        bus.done   = 1'b0;
        case (state)
            S_IDLE: begin
                bus.ready = 1'b1;
                if (accept) begin
                    next_state = special ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                bus.stall = 1'b1;
                if (bus.flush) begin
                    next_state = S_IDLE;
                end else if (cnt == CNT_W'(1)) begin
                    next_state = S_FIX;
                end
            end
            S_FIX: begin
                bus.stall  = 1'b1;
                next_state = bus.flush ? S_IDLE : S_DONE;
            end
            S_DONE: begin
                bus.done   = 1'b1;
                next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt      <= '0;
            op_q     <= '0;
            rd_q     <= '0;
            rd_out_q <= '0;
            mag_b    <= '0;
            result_q <= '0;
            acc      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_q  <= bus.op;
                        rd_q  <= bus.rd_in;
                        mag_b <= abs_b;
                        acc   <= {{XLEN{1'b0}}, abs_a};
                        neg_q <= sign_a ^ sign_b;
                        neg_r <= sign_a;
                        cnt   <= CNT_W'(N_ITER);
                        if (special) begin
                            result_q <= special_val;
                            rd_out_q <= bus.rd_in;
                        end
                    end
                end
                S_CALC: begin
                    acc <= acc_step;
                    cnt <= cnt - CNT_W'(1);
                end
                S_FIX: begin
                    // A flushed operation leaves the previous result visible.
                    if (!bus.flush) begin
                        result_q <= fix_val;
                        rd_out_q <= rd_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.result = result_q;
    assign bus.rd_out = rd_out_q;
endmodule
